// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and defaults for the 512x22 single-port SRAM arbiter/controller.
package ct_spsram_ctrl_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_e;

   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_DATA_WIDTH = 22;
   localparam int STARVE_CNT_W   = 4;

endpackage

// File: rtl/ct_spsram_sweep_cnt.sv
// Address counter for the clear sweep: synchronous clear, count enable,
// and a flag marking the last array address.
module ct_spsram_sweep_cnt
   import ct_spsram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   output logic [ADDR_WIDTH-1:0] cnt,
   output logic                  last
);

   logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign last = &cnt_q;

endmodule

// File: rtl/ct_spsram_512x22_arb_ctrl.sv
// Shares one single-port SRAM between a read and a write requester and owns
// the clear sweep that fills the array with INIT_DATA after reset/invalidate.
module ct_spsram_512x22_arb_ctrl
   import ct_spsram_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0,
   parameter int                    STARVE_MAX = 4
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  inv_all_req,
   output logic                  init_done,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_bwe,
   output logic                  wr_gnt,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   state_e                  state_d, state_q;
   logic [STARVE_CNT_W-1:0] starve_d, starve_q;
   logic                    rd_vld_d, rd_vld_q;
   logic                    init_done_d, init_done_q;
   logic [ADDR_WIDTH-1:0]   a_d, a_q;
   logic [DATA_WIDTH-1:0]   d_d, d_q;
   logic [ADDR_WIDTH-1:0]   sweep_cnt;
   logic                    sweep_last, sweep_wr, sweep_clr, arb_en, force_rd;

   assign sweep_wr  = !cpurst && (state_q == ST_SWEEP);
   assign arb_en    = !cpurst && (state_q == ST_IDLE);
   assign sweep_clr = cpurst || (arb_en && inv_all_req);

   // A starved reader takes exactly one cycle from the writer, then priority reverts.
   assign force_rd = (starve_q == STARVE_LIM) && rd_req;
   assign wr_gnt   = arb_en && wr_req && !force_rd;
   assign rd_gnt   = arb_en && rd_req && (!wr_req || force_rd);

   ct_spsram_sweep_cnt #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sweep_cnt (
      .clk  (forever_cpuclk),
      .clr  (sweep_clr),
      .en   (sweep_wr),
      .cnt  (sweep_cnt),
      .last (sweep_last)
   );

   always_comb begin
      state_d = state_q;
      if (sweep_wr && sweep_last) begin
         state_d = ST_IDLE;
      end else if (arb_en && inv_all_req) begin
         state_d = ST_SWEEP;
      end

      starve_d = '0;
      if (rd_req && !rd_gnt) begin
         starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
      end

      rd_vld_d    = rd_gnt;
      init_done_d = (state_d == ST_IDLE);

      // Address/data pins keep their previous value whenever unused to avoid toggling.
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      a_d       = a_q;
      d_d       = d_q;
      if (sweep_wr) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         a_d       = sweep_cnt;
         d_d       = INIT_DATA;
      end else if (wr_gnt) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = ~wr_bwe;
         a_d       = wr_addr;
         d_d       = wr_data;
      end else if (rd_gnt) begin
         sram_cen  = 1'b0;
         a_d       = rd_addr;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q     <= ST_SWEEP;
         starve_q    <= '0;
         rd_vld_q    <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         rd_vld_q    <= rd_vld_d;
         init_done_q <= init_done_d;
      end
      a_q <= a_d;
      d_q <= d_d;
   end

   assign sram_a    = a_d;
   assign sram_d    = d_d;
   assign rd_vld    = rd_vld_q && !cpurst;
   assign rd_data   = sram_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_ct_spsram_512x22_arb_ctrl.sv
// Bench for ct_spsram_512x22_arb_ctrl: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the arbiter and array.
module tb_ct_spsram_512x22_arb_ctrl;

   localparam int AW    = 9;
   localparam int DW    = 22;
   localparam int DEPTH = 512;
   localparam int SMAX  = 4;
   localparam logic [DW-1:0] INIT = '0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          cpurst, inv_all_req, rd_req, wr_req;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] wr_data, wr_bwe;
   logic          init_done, rd_gnt, rd_vld, wr_gnt;
   logic [DW-1:0] rd_data;
   logic          sram_cen, sram_gwen;
   logic [DW-1:0] sram_wen, sram_d, sram_q;
   logic [AW-1:0] sram_a;

   int checks   = 0;
   int failures = 0;

   ct_spsram_512x22_arb_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .INIT_DATA  (INIT),
      .STARVE_MAX (SMAX)
   ) dut (
      .forever_cpuclk (clk),
      .cpurst         (cpurst),
      .inv_all_req    (inv_all_req),
      .init_done      (init_done),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_gnt         (rd_gnt),
      .rd_vld         (rd_vld),
      .rd_data        (rd_data),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_bwe         (wr_bwe),
      .wr_gnt         (wr_gnt),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_wen       (sram_wen),
      .sram_a         (sram_a),
      .sram_d         (sram_d),
      .sram_q         (sram_q)
   );

   // Behavioural single-port SRAM macro: active-low controls, registered read data.
   logic [DW-1:0] sram_mem [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= DW'($urandom);
   end
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) begin
            for (int i = 0; i < DW; i++) begin
               if (!sram_wen[i]) sram_mem[sram_a][i] <= sram_d[i];
            end
         end else begin
            sram_q <= sram_mem[sram_a];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   bit            m_sweep = 1'b1;
   int            m_pos = 0;
   int            m_starve = 0;
   bit            m_vld = 1'b0;
   bit            m_init = 1'b0;
   logic [DW-1:0] m_rdata;
   logic [DW-1:0] m_mem [DEPTH];
   bit            have_last = 1'b0;
   logic [AW-1:0] last_a;
   logic [DW-1:0] last_d;
   logic          g_rd, g_wr;
   logic [DW-1:0] exp_wen;

   always @(negedge clk) begin
      g_rd = 1'b0;
      g_wr = 1'b0;
      chk("init_done", 32'(init_done), 32'(m_init));
      chk("rd_vld", 32'(rd_vld), 32'(m_vld && !cpurst));
      if (m_vld && !cpurst) chk("rd_data", 32'(rd_data), 32'(m_rdata));
      if (cpurst) begin
         chk("rst_rd_gnt", 32'(rd_gnt), 0);
         chk("rst_wr_gnt", 32'(wr_gnt), 0);
         chk("rst_cen", 32'(sram_cen), 1);
         chk("rst_gwen", 32'(sram_gwen), 1);
         chk("rst_wen", 32'(sram_wen), 32'({DW{1'b1}}));
         if (have_last) begin
            chk("rst_a_hold", 32'(sram_a), 32'(last_a));
            chk("rst_d_hold", 32'(sram_d), 32'(last_d));
         end
         m_sweep = 1'b1; m_pos = 0; m_starve = 0; m_vld = 1'b0; m_init = 1'b0;
      end else begin
         if (m_sweep) begin
            chk("sweep_rd_gnt", 32'(rd_gnt), 0);
            chk("sweep_wr_gnt", 32'(wr_gnt), 0);
            chk("sweep_cen", 32'(sram_cen), 0);
            chk("sweep_gwen", 32'(sram_gwen), 0);
            chk("sweep_wen", 32'(sram_wen), 0);
            chk("sweep_a", 32'(sram_a), 32'(m_pos));
            chk("sweep_d", 32'(sram_d), 32'(INIT));
            m_mem[m_pos] = INIT;
            last_a = AW'(m_pos); last_d = INIT; have_last = 1'b1;
            m_pos++;
            if (m_pos == DEPTH) begin
               m_sweep = 1'b0;
               m_pos = 0;
            end
         end else begin
            if (rd_req && (m_starve == SMAX || !wr_req)) g_rd = 1'b1;
            else if (wr_req) g_wr = 1'b1;
            chk("rd_gnt", 32'(rd_gnt), 32'(g_rd));
            chk("wr_gnt", 32'(wr_gnt), 32'(g_wr));
            if (g_wr) begin
               exp_wen = ~wr_bwe;
               chk("wr_cen", 32'(sram_cen), 0);
               chk("wr_gwen", 32'(sram_gwen), 0);
               chk("wr_wen", 32'(sram_wen), 32'(exp_wen));
               chk("wr_a", 32'(sram_a), 32'(wr_addr));
               chk("wr_d", 32'(sram_d), 32'(wr_data));
               m_mem[wr_addr] = (m_mem[wr_addr] & ~wr_bwe) | (wr_data & wr_bwe);
               last_a = wr_addr; last_d = wr_data; have_last = 1'b1;
            end else if (g_rd) begin
               chk("rd_cen", 32'(sram_cen), 0);
               chk("rd_gwen", 32'(sram_gwen), 1);
               chk("rd_wen", 32'(sram_wen), 32'({DW{1'b1}}));
               chk("rd_a", 32'(sram_a), 32'(rd_addr));
               if (have_last) chk("rd_d_hold", 32'(sram_d), 32'(last_d));
               m_rdata = m_mem[rd_addr];
               last_a = rd_addr; have_last = 1'b1;
            end else begin
               chk("idle_cen", 32'(sram_cen), 1);
               if (have_last) begin
                  chk("idle_a_hold", 32'(sram_a), 32'(last_a));
                  chk("idle_d_hold", 32'(sram_d), 32'(last_d));
               end
            end
            if (inv_all_req) begin
               m_sweep = 1'b1;
               m_pos = 0;
            end
         end
         m_starve = (rd_req && !g_rd) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
         m_vld  = g_rd;
         m_init = !m_sweep;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      rd_req = 1'b0; wr_req = 1'b0; inv_all_req = 1'b0;
   endtask

   initial begin
      int n, ng;
      bit done, rg, wg;
      cpurst = 1'b1; idle_in();
      rd_addr = '0; wr_addr = '0; wr_data = '0; wr_bwe = '0;
      repeat (3) step();

      // Initial sweep: writes in cycles 1..512, init_done from 513
      cpurst = 1'b0;
      @(negedge clk); chk("t1_first_a", 32'(sram_a), 0); chk("t1_first_cen", 32'(sram_cen), 0);
      repeat (511) step();
      @(negedge clk); chk("t1_last_a", 32'(sram_a), 511); chk("t1_init_512", 32'(init_done), 0);
      step();
      @(negedge clk); chk("t1_init_513", 32'(init_done), 1); chk("t1_idle_cen", 32'(sram_cen), 1);

      // Full write then read-back
      step(); wr_req = 1'b1; wr_addr = 9'h1A5; wr_data = 22'h2AAAAA; wr_bwe = '1;
      @(negedge clk); chk("t2_wr_gnt", 32'(wr_gnt), 1);
      step(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 9'h1A5;
      @(negedge clk); chk("t2_rd_gnt", 32'(rd_gnt), 1);
      step(); rd_req = 1'b0;
      @(negedge clk); chk("t2_rd_vld", 32'(rd_vld), 1); chk("t2_rd_data", 32'(rd_data), 32'h2AAAAA);

      // Partial write
      step(); wr_req = 1'b1; wr_addr = 9'd7; wr_data = 22'h3FFFFF; wr_bwe = 22'h0007FF;
      @(negedge clk); chk("t3_wen", 32'(sram_wen), 32'h3FF800);
      step(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 9'd7;
      step(); rd_req = 1'b0;
      @(negedge clk); chk("t3_rd_data", 32'(rd_data), 32'h0007FF);

      // Starvation: 4 writes, 1 forced read, then writes again
      step(); rd_req = 1'b1; wr_req = 1'b1; rd_addr = 9'd7; wr_addr = 9'h010;
      wr_data = 22'h155555; wr_bwe = '1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t4_wr_gnt", 32'(wr_gnt), (i == 4) ? 0 : 1);
         chk("t4_rd_gnt", 32'(rd_gnt), (i == 4) ? 1 : 0);
         step();
      end
      idle_in();

      // Invalidate with a read pending, second invalidate absorbed mid-sweep
      step(); rd_req = 1'b1; rd_addr = 9'h1A5; inv_all_req = 1'b1;
      @(negedge clk); chk("t5_rd_gnt_inv", 32'(rd_gnt), 1);
      step(); idle_in(); wr_req = 1'b1; wr_addr = 9'h020; wr_data = 22'h0F0F0F; wr_bwe = '1;
      n = 0; ng = 0; done = 1'b0;
      for (int c = 0; c < 600 && !done; c++) begin
         inv_all_req = (c == 100);
         @(negedge clk);
         if (init_done) done = 1'b1;
         else begin
            n++;
            if (rd_gnt || wr_gnt) ng++;
         end
         step();
      end
      idle_in();
      chk("t5_done", 32'(done), 1); chk("t5_sweep_len", n, 512); chk("t5_no_gnt", ng, 0);

      // Reset drops a pending rd_vld; reset at sweep addr 300 restarts from 0
      rd_req = 1'b1; rd_addr = 9'h020;
      @(negedge clk); chk("t6_rd_gnt", 32'(rd_gnt), 1);
      step(); rd_req = 1'b0; cpurst = 1'b1;
      @(negedge clk); chk("t6_vld_drop", 32'(rd_vld), 0); chk("t6_rst_cen", 32'(sram_cen), 1);
      step(); step(); cpurst = 1'b0;
      @(negedge clk); chk("t6_restart_a0", 32'(sram_a), 0);
      repeat (299) step();
      @(negedge clk); chk("t6_a_299", 32'(sram_a), 299);
      step(); cpurst = 1'b1;
      @(negedge clk); chk("t6_rst300_cen", 32'(sram_cen), 1);
      step(); cpurst = 1'b0;
      @(negedge clk); chk("t6_restart2_a0", 32'(sram_a), 0); chk("t6_restart2_cen", 32'(sram_cen), 0);
      step();
      n = 1; done = 1'b0;
      for (int c = 0; c < 600 && !done; c++) begin
         @(negedge clk);
         if (init_done) done = 1'b1; else n++;
         step();
      end
      chk("t6_done", 32'(done), 1); chk("t6_sweep_len", n, 512);

      // Random traffic; requests held until granted
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rg = rd_gnt; wg = wr_gnt;
         step();
         cpurst = cpurst ? 1'b0 : ($urandom_range(0, 1999) == 0);
         inv_all_req = ($urandom_range(0, 899) == 0);
         if (!rd_req || rg) begin
            rd_req  = ($urandom_range(0, 2) != 0);
            rd_addr = ($urandom_range(0, 7) == 0) ? 9'h1FF : AW'($urandom_range(0, 15));
         end
         if (!wr_req || wg) begin
            int k;
            k = $urandom_range(0, 3);
            wr_req  = ($urandom_range(0, 1) != 0);
            wr_addr = ($urandom_range(0, 7) == 0) ? 9'h1FF : AW'($urandom_range(0, 15));
            wr_data = DW'($urandom);
            wr_bwe  = (k == 0) ? '0 : (k == 1) ? '1 : DW'($urandom);
         end
      end
      idle_in(); cpurst = 1'b0;
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
